// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared board constants, scan-port arbiter states and requester IDs.
package gomoku_pkg;
    localparam int BOARD_SIZE = 15;
    localparam int COORD_W    = 4;
    typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;
    typedef enum logic {REQ_WIN = 1'b0, REQ_AI = 1'b1} req_id_t;
endpackage

// File: rtl/scan_port_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick; the pointer only moves when both requesters collide.
module rr_arbiter2 import gomoku_pkg::*; (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);
    always_comb begin
        gnt     = &req ? (ptr == REQ_AI ? 2'b10 : 2'b01) : req;
        ptr_nxt = &req ? ~ptr : ptr;
    end
endmodule

// File: rtl/scan_port_arbiter.sv
// scan_port_arbiter: shares the board-window read port between the win checker (0) and the AI evaluator (1).
module scan_port_arbiter import gomoku_pkg::*; #(
    parameter int BOARD_SIZE = gomoku_pkg::BOARD_SIZE,
    parameter int MAX_LOCK   = 256,
    parameter int LOCK_CNT_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               req0,
    input  logic               lock0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x0,
    output logic               gnt0,
    output logic               vld0,
    input  logic               req1,
    input  logic               lock1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x1,
    output logic               gnt1,
    output logic               vld1,
    output logic [COORD_W-1:0] port_y,
    output logic [COORD_W-1:0] port_x,
    output logic               port_en,
    output logic               oob,
    output logic               lock_err
);
    localparam logic [COORD_W-1:0]    LIMIT    = COORD_W'(BOARD_SIZE);
    localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(MAX_LOCK - 1);

    state_t                 state, state_nxt;
    logic                   rr_ptr, rr_nxt, rr_pick, expired, hit, in_range;
    logic [1:0]             pick;
    logic [LOCK_CNT_W-1:0]  cnt;
    logic [COORD_W-1:0]     sel_y, sel_x;

    rr_arbiter2 u_rr (.req({req1, req0}), .ptr(rr_ptr), .gnt(pick), .ptr_nxt(rr_pick));

    assign expired  = state != ARB && cnt == CNT_LAST;
    assign hit      = gnt0 | gnt1;
    assign sel_y    = gnt1 ? y1 : y0;
    assign sel_x    = gnt1 ? x1 : x0;
    assign in_range = sel_y < LIMIT && sel_x < LIMIT;

    // Leaving a lock, for any reason, hands priority to the requester that was locked out.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        case (state)
            ARB: begin
                {gnt1, gnt0} = pick;
                rr_nxt       = rr_pick;
                if (pick[0] && lock0)      state_nxt = LOCK0;
                else if (pick[1] && lock1) state_nxt = LOCK1;
            end
            LOCK0: begin
                gnt0 = req0;
                if (!lock0 || expired) begin
                    state_nxt = ARB;
                    rr_nxt    = REQ_AI;
                end
            end
            LOCK1: begin
                gnt1 = req1;
                if (!lock1 || expired) begin
                    state_nxt = ARB;
                    rr_nxt    = REQ_WIN;
                end
            end
            default: state_nxt = ARB;
        endcase
        if (!rst || clr) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            {rr_ptr, cnt, lock_err, vld0, vld1, port_en, oob, port_y, port_x} <= '0;
        end else if (clr) begin
            state <= ARB;
            {rr_ptr, cnt, lock_err, vld0, vld1, port_en, oob, port_y, port_x} <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_nxt;
            cnt      <= state == ARB ? '0 : cnt + 1'b1;
            lock_err <= lock_err | expired;
            vld0     <= gnt0;
            vld1     <= gnt1;
            port_en  <= hit & in_range;
            oob      <= hit & ~in_range;
            if (hit && in_range) begin
                port_y <= sel_y;
                port_x <= sel_x;
            end
        end
    end
endmodule

// File: tb/tb_scan_port_arbiter.sv
// tb_scan_port_arbiter: scenario tasks plus a randomized run, all checked against a rule-level reference model.
module tb_scan_port_arbiter;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
    logic req0 = 1'b0, lock0 = 1'b0, req1 = 1'b0, lock1 = 1'b0;
    logic [3:0] y0 = '0, x0 = '0, y1 = '0, x1 = '0;
    logic gnt0, gnt1, vld0, vld1, port_en, oob, lock_err;
    logic [3:0] port_y, port_x;
    int checks = 0, errors = 0;

    scan_port_arbiter dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req0(req0), .lock0(lock0), .y0(y0), .x0(x0), .gnt0(gnt0), .vld0(vld0),
        .req1(req1), .lock1(lock1), .y1(y1), .x1(x1), .gnt1(gnt1), .vld1(vld1),
        .port_y(port_y), .port_x(port_x), .port_en(port_en), .oob(oob), .lock_err(lock_err)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, how long it has held it, whose turn it is.
    int owner = -1, age = 0, prio = 0, win = -1;
    logic e_g0, e_g1, e_v0, e_v1, e_en, e_oob, e_err;
    logic [3:0] e_y, e_x;

    task automatic model_reset();
        owner = -1; age = 0; prio = 0; win = -1;
        {e_g0, e_g1, e_v0, e_v1, e_en, e_oob, e_err} = '0;
        e_y = '0; e_x = '0;
    endtask

    task automatic model_gnt();
        win = -1;
        if (!clr) begin
            if (owner >= 0) win = (owner == 0 ? req0 : req1) ? owner : -1;
            else if (req0 && req1) win = prio;
            else if (req0) win = 0;
            else if (req1) win = 1;
        end
        e_g0 = win == 0;
        e_g1 = win == 1;
    endtask

    task automatic model_edge();
        int y, x;
        bit ok, lk;
        if (clr) begin
            model_reset();
            return;
        end
        y = win == 1 ? int'(y1) : int'(y0);
        x = win == 1 ? int'(x1) : int'(x0);
        lk = win == 1 ? lock1 : lock0;
        ok = y < 15 && x < 15;
        e_v0 = win == 0;
        e_v1 = win == 1;
        e_en = win >= 0 && ok;
        e_oob = win >= 0 && !ok;
        if (e_en) begin
            e_y = 4'(y);
            e_x = 4'(x);
        end
        if (owner < 0) begin
            if (req0 && req1) prio = 1 - prio;
            if (win >= 0 && lk) begin
                owner = win;
                age = 0;
            end
        end else begin
            age++;
            if (age == 256) e_err = 1'b1;
            if (age == 256 || !(owner == 0 ? lock0 : lock1)) begin
                prio = 1 - owner;
                owner = -1;
            end
        end
    endtask

    task automatic settle();
        #1;
        model_gnt();
    endtask

    task automatic clock();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0 = 1'b1;
        y0 = 4'd5;
        #1;
        checks++;
        if ({gnt0, gnt1, vld0, vld1, port_en, oob, lock_err, port_y, port_x} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {gnt0, gnt1, vld0, vld1, port_en, oob, lock_err, port_y, port_x});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        y0 = '0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        req0 = 1'b1; lock0 = 1'b0; y0 = 4'd3; x0 = 4'd7;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b10 || {gnt0, gnt1} !== {e_g0, e_g1}) begin
            errors++;
            $display("FAIL single_gnt: got %b%b want 10", gnt0, gnt1);
        end
        clock();
        checks++;
        if ({port_y, port_x, port_en, vld0, vld1} !== {4'd3, 4'd7, 3'b110}) begin
            errors++;
            $display("FAIL single_port: got y=%0d x=%0d en=%b v0=%b v1=%b want 3 7 1 1 0", port_y, port_x, port_en, vld0, vld1);
        end
        req0 = 1'b0;
        settle();
        clock();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; req1 = 1'b1; lock0 = 1'b0; lock1 = 1'b0;
            y0 = 4'(i); x0 = 4'd1; y1 = 4'(i + 8); x1 = 4'd2;
            settle();
            checks++;
            if ({gnt0, gnt1} !== (i % 2 == 0 ? 2'b10 : 2'b01) || {gnt0, gnt1} !== {e_g0, e_g1}) begin
                errors++;
                $display("FAIL alt_gnt cyc %0d: got %b%b model %b%b", i, gnt0, gnt1, e_g0, e_g1);
            end
            clock();
            checks++;
            if ({vld0, vld1, port_en, oob, lock_err, port_y, port_x} !== {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x}) begin
                errors++;
                $display("FAIL alt_out cyc %0d: got %h want %h", i, {vld0, vld1, port_en, oob, lock_err, port_y, port_x}, {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        settle();
        clock();
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 225; i++) begin
            req1 = 1'b1; lock1 = i != 224; y1 = 4'(i / 15); x1 = 4'(i % 15);
            req0 = i != 0; lock0 = 1'b0; y0 = 4'd9; x0 = 4'd9;
            settle();
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b1 || {gnt0, gnt1} !== {e_g0, e_g1}) begin
                errors++;
                $display("FAIL sweep_gnt cell %0d: got %b%b want 01", i, gnt0, gnt1);
            end
            clock();
            checks++;
            if ({vld0, vld1, port_en, port_y, port_x} !== {3'b011, 4'(i / 15), 4'(i % 15)}) begin
                errors++;
                $display("FAIL sweep_port cell %0d: got v=%b%b en=%b y=%0d x=%0d", i, vld0, vld1, port_en, port_y, port_x);
            end
        end
        req1 = 1'b0; lock1 = 1'b0; req0 = 1'b1;
        settle();
        checks++;
        if (gnt0 !== 1'b1 || gnt0 !== e_g0) begin
            errors++;
            $display("FAIL sweep_release: got gnt0=%b want 1", gnt0);
        end
        clock();
        checks++;
        if (lock_err !== 1'b0) begin
            errors++;
            $display("FAIL sweep_lock_err: got %b want 0", lock_err);
        end
    endtask

    task automatic test_watchdog();
        int first_g1 = -1;
        for (int i = 0; i < 300; i++) begin
            req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
            y0 = 4'(i % 15); x0 = 4'd4; y1 = 4'd6; x1 = 4'(i % 15);
            settle();
            if (gnt1 === 1'b1 && first_g1 < 0) first_g1 = i;
            checks++;
            if ({gnt0, gnt1} !== {e_g0, e_g1}) begin
                errors++;
                $display("FAIL wd_gnt cyc %0d: got %b%b want %b%b", i, gnt0, gnt1, e_g0, e_g1);
            end
            clock();
            checks++;
            if ({vld0, vld1, port_en, oob, lock_err, port_y, port_x} !== {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x}) begin
                errors++;
                $display("FAIL wd_out cyc %0d: got %h want %h", i, {vld0, vld1, port_en, oob, lock_err, port_y, port_x}, {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x});
            end
        end
        checks++;
        if (first_g1 != 257) begin
            errors++;
            $display("FAIL wd_release_cycle: got %0d want 257", first_g1);
        end
        checks++;
        if (lock_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky: got %b want 1", lock_err);
        end
        req0 = 1'b0; lock0 = 1'b0; req1 = 1'b0;
        repeat (2) begin
            settle();
            clock();
        end
    endtask

    task automatic test_oob();
        logic [3:0] hy, hx;
        hy = e_y;
        hx = e_x;
        req1 = 1'b1; lock1 = 1'b0; y1 = 4'd15; x1 = 4'd2; req0 = 1'b0;
        settle();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL oob_gnt: got %b want 1", gnt1);
        end
        clock();
        checks++;
        if ({vld1, oob, port_en, port_y, port_x} !== {3'b110, hy, hx}) begin
            errors++;
            $display("FAIL oob_out: got v1=%b oob=%b en=%b y=%0d x=%0d want 1 1 0 %0d %0d", vld1, oob, port_en, port_y, port_x, hy, hx);
        end
        req1 = 1'b0;
        settle();
        clock();
        checks++;
        if ({vld1, oob, port_en} !== 3'b000) begin
            errors++;
            $display("FAIL oob_oneshot: got v1=%b oob=%b en=%b want 000", vld1, oob, port_en);
        end
    endtask

    task automatic test_clr();
        req1 = 1'b1; lock1 = 1'b1; y1 = 4'd2; x1 = 4'd3; req0 = 1'b0;
        settle();
        clock();
        clr = 1'b1;
        settle();
        checks++;
        if (vld1 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_pre: got vld1=%b gnt1=%b want 1 0", vld1, gnt1);
        end
        clock();
        checks++;
        if ({gnt0, gnt1, vld0, vld1, port_en, oob, lock_err, port_y, port_x} !== 15'd0) begin
            errors++;
            $display("FAIL clr_outputs: got %h want 0", {gnt0, gnt1, vld0, vld1, port_en, oob, lock_err, port_y, port_x});
        end
        clr = 1'b0; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL clr_arb: got %b%b want 10", gnt0, gnt1);
        end
        clock();
        req0 = 1'b0; req1 = 1'b0;
        settle();
        clock();
    endtask

    task automatic test_reset_midlock();
        req1 = 1'b1; lock1 = 1'b1; y1 = 4'd4; x1 = 4'd4;
        settle();
        clock();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt1, vld1, port_en} !== 3'b000) begin
            errors++;
            $display("FAIL rst_midlock: got gnt1=%b vld1=%b en=%b want 000", gnt1, vld1, port_en);
        end
        model_reset();
        @(negedge clk);
        req1 = 1'b0; lock1 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        req0 = 1'b1; req1 = 1'b1;
        settle();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL rst_midlock_arb: got %b%b want 10", gnt0, gnt1);
        end
        clock();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            req0 = $urandom_range(0, 3) != 0;
            req1 = $urandom_range(0, 3) != 0;
            lock0 = $urandom_range(0, 3) == 0;
            lock1 = $urandom_range(0, 3) == 0;
            y0 = 4'($urandom_range(0, 15)); x0 = 4'($urandom_range(0, 15));
            y1 = 4'($urandom_range(0, 15)); x1 = 4'($urandom_range(0, 15));
            clr = $urandom_range(0, 63) == 0;
            settle();
            checks++;
            if ({gnt0, gnt1} !== {e_g0, e_g1}) begin
                errors++;
                $display("FAIL rand_gnt cyc %0d: got %b%b want %b%b", i, gnt0, gnt1, e_g0, e_g1);
            end
            clock();
            checks++;
            if ({vld0, vld1, port_en, oob, lock_err, port_y, port_x} !== {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x}) begin
                errors++;
                $display("FAIL rand_out cyc %0d: got %h want %h", i, {vld0, vld1, port_en, oob, lock_err, port_y, port_x}, {e_v0, e_v1, e_en, e_oob, e_err, e_y, e_x});
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_sweep();
        test_watchdog();
        test_oob();
        test_clr();
        test_reset_midlock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
